// File: rtl/jelly_buffer_writer_sequencer.sv
// Writer-side sequencer for the buffer manager: per accepted frame it requests a buffer,
// launches one DMA write into it, waits for completion or timeout, then releases the buffer.
module jelly_buffer_writer_sequencer #(
  parameter int ADDR_WIDTH    = 32,
  parameter int INDEX_WIDTH   = 2,
  parameter int REQ_LATENCY   = 1,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,
  input  logic                     enable,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  input  logic                     frame_start,
  output logic                     buffer_request,
  output logic                     buffer_release,
  input  logic [ADDR_WIDTH-1:0]    buffer_addr,
  input  logic [INDEX_WIDTH-1:0]   buffer_index,
  output logic                     dma_valid,
  input  logic                     dma_ready,
  output logic [ADDR_WIDTH-1:0]    dma_addr,
  input  logic                     dma_done,
  output logic                     busy,
  output logic [INDEX_WIDTH-1:0]   current_index,
  output logic [COUNT_WIDTH-1:0]   frame_count,
  output logic [COUNT_WIDTH-1:0]   skip_count,
  output logic [COUNT_WIDTH-1:0]   timeout_count
);

  localparam int WAIT_W = (REQ_LATENCY < 2) ? 1 : $clog2(REQ_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(REQ_LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ADDR = 3'd1,
    ST_START     = 3'd2,
    ST_RUN       = 3'd3,
    ST_RELEASE   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic [ADDR_WIDTH-1:0]    dma_addr_q, dma_addr_d;
  logic [INDEX_WIDTH-1:0]   current_index_q, current_index_d;
  logic                     dma_valid_q, dma_valid_d;
  logic                     buffer_request_q, buffer_request_d;
  logic                     buffer_release_q, buffer_release_d;
  logic [COUNT_WIDTH-1:0]   frame_count_q, frame_count_d;
  logic [COUNT_WIDTH-1:0]   skip_count_q, skip_count_d;
  logic [COUNT_WIDTH-1:0]   timeout_count_q, timeout_count_d;

  // DMA command handshake: a command transfers on a clock edge (with cke) where dma_valid and
  // dma_ready are both high; until then dma_valid and dma_addr are held stable.
  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    timer_d          = timer_q;
    dma_addr_d       = dma_addr_q;
    current_index_d  = current_index_q;
    dma_valid_d      = dma_valid_q;
    buffer_request_d = buffer_request_q;
    buffer_release_d = buffer_release_q;
    frame_count_d    = frame_count_q;
    skip_count_d     = skip_count_q;
    timeout_count_d  = timeout_count_q;

    if (cke) begin
      buffer_request_d = 1'b0;
      buffer_release_d = 1'b0;

      // Frames arriving mid-flight are dropped, not queued.
      if ((state_q != ST_IDLE) && enable && frame_start) begin
        skip_count_d = skip_count_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (enable && frame_start) begin
            buffer_request_d = 1'b1;
            wait_cnt_d       = '0;
            state_d          = ST_WAIT_ADDR;
          end
        end
        ST_WAIT_ADDR: begin
          if (wait_cnt_q == WAIT_LAST) begin
            dma_addr_d      = buffer_addr;
            current_index_d = buffer_index;
            dma_valid_d     = 1'b1;
            state_d         = ST_START;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        ST_START: begin
          if (dma_ready) begin
            dma_valid_d = 1'b0;
            timer_d     = '0;
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          timer_d = timer_q + 1'b1;
          // Completion takes priority over a timeout expiring in the same cycle.
          if (dma_done) begin
            frame_count_d    = frame_count_q + 1'b1;
            buffer_release_d = 1'b1;
            state_d          = ST_RELEASE;
          end else if ((param_timeout != '0) && (timer_q == param_timeout - 1'b1)) begin
            timeout_count_d  = timeout_count_q + 1'b1;
            buffer_release_d = 1'b1;
            state_d          = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      wait_cnt_q       <= '0;
      timer_q          <= '0;
      dma_addr_q       <= '0;
      current_index_q  <= '0;
      dma_valid_q      <= 1'b0;
      buffer_request_q <= 1'b0;
      buffer_release_q <= 1'b0;
      frame_count_q    <= '0;
      skip_count_q     <= '0;
      timeout_count_q  <= '0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      timer_q          <= timer_d;
      dma_addr_q       <= dma_addr_d;
      current_index_q  <= current_index_d;
      dma_valid_q      <= dma_valid_d;
      buffer_request_q <= buffer_request_d;
      buffer_release_q <= buffer_release_d;
      frame_count_q    <= frame_count_d;
      skip_count_q     <= skip_count_d;
      timeout_count_q  <= timeout_count_d;
    end
  end

  assign buffer_request = buffer_request_q;
  assign buffer_release = buffer_release_q;
  assign dma_valid      = dma_valid_q;
  assign dma_addr       = dma_addr_q;
  assign busy           = (state_q != ST_IDLE);
  assign current_index  = current_index_q;
  assign frame_count    = frame_count_q;
  assign skip_count     = skip_count_q;
  assign timeout_count  = timeout_count_q;

endmodule

// File: tb/tb_jelly_buffer_writer_sequencer.sv
// Bench for jelly_buffer_writer_sequencer: buffer-manager and DMA responder models, a release
// scoreboard, a vector table of frame scenarios, hand-written cke/reset sequences, random frames.
module tb_jelly_buffer_writer_sequencer;

  localparam int AW = 32;
  localparam int IW = 2;
  localparam int L  = 1;
  localparam int TW = 24;
  localparam int CW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset, cke, enable, frame_start;
  logic [TW-1:0] param_timeout;
  logic          buffer_request, buffer_release;
  logic [AW-1:0] buffer_addr, dma_addr;
  logic [IW-1:0] buffer_index, current_index;
  logic          dma_valid, dma_ready, dma_done, busy;
  logic [CW-1:0] frame_count, skip_count, timeout_count;

  always #5 clk = ~clk;

  jelly_buffer_writer_sequencer #(
    .ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .REQ_LATENCY(L), .TIMEOUT_WIDTH(TW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .cke(cke), .enable(enable), .param_timeout(param_timeout),
    .frame_start(frame_start), .buffer_request(buffer_request), .buffer_release(buffer_release),
    .buffer_addr(buffer_addr), .buffer_index(buffer_index), .dma_valid(dma_valid),
    .dma_ready(dma_ready), .dma_addr(dma_addr), .dma_done(dma_done), .busy(busy),
    .current_index(current_index), .frame_count(frame_count), .skip_count(skip_count),
    .timeout_count(timeout_count)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [CW-1:0] exp_frames = '0, exp_skips = '0, exp_timeouts = '0;
  logic [IW-1:0] exp_q[$];

  int            cyc = 0;
  logic [7:0]    req_pipe = '0;
  logic [AW-1:0] cur_addr = '0;
  logic [IW-1:0] cur_idx = '0;
  int            cur_r = 0, cur_d = 0;
  bit            extra_done = 1'b0;
  int            req_cnt = 0, rel_cnt = 0, both_cnt = 0, valid_cycles = 0, addr_bad = 0;
  int            hs_cyc = -1, rel_cyc = -1;
  logic [AW-1:0] valid_addr = '0;
  logic          prev_req = 1'b0, prev_rel = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  // ---------------- driver: buffer manager + DMA responder ----------------
  always @(posedge clk) begin
    cyc++;
    #1;
    buffer_addr  = req_pipe[L-1] ? cur_addr : (cur_addr ^ 32'hFFFF_0F0F);
    buffer_index = req_pipe[L-1] ? cur_idx : ~cur_idx;
    dma_ready    = (valid_cycles >= cur_r);
    dma_done     = extra_done || ((hs_cyc >= 0) && (cur_d > 0) && (cyc == hs_cyc + cur_d));
  end

  // ---------------- monitor + release scoreboard ----------------
  always @(negedge clk) begin
    req_pipe = {req_pipe[6:0], buffer_request};
    if (buffer_request && !prev_req) req_cnt++;
    if (buffer_release && !prev_rel) begin
      rel_cnt++;
      if (rel_cyc < 0) rel_cyc = cyc;
      if (exp_q.size() == 0) check("release_unexpected", 1, 0);
      else check("release_index", current_index, exp_q.pop_front());
    end
    if (buffer_request && buffer_release) both_cnt++;
    if (dma_valid) begin
      if (valid_cycles == 0) valid_addr = dma_addr;
      else if (dma_addr != valid_addr) addr_bad++;
      valid_cycles++;
      if (dma_ready && hs_cyc < 0) hs_cyc = cyc;
    end
    prev_req = buffer_request;
    prev_rel = buffer_release;
  end

  // ---------------- frame driver ----------------
  task automatic setup_frame(input logic [AW-1:0] addr, input logic [IW-1:0] idx,
                             input int r, input int d, input int p);
    cur_addr = addr; cur_idx = idx; cur_r = r; cur_d = d;
    param_timeout = TW'(p);
    req_cnt = 0; rel_cnt = 0; both_cnt = 0; valid_cycles = 0; addr_bad = 0;
    hs_cyc = -1; rel_cyc = -1;
    exp_q.push_back(idx);
  endtask

  task automatic run_frame(input logic [AW-1:0] addr, input logic [IW-1:0] idx, input int r,
                           input int d, input int p, input int k, input logic [2:0] en,
                           input bit exp_done, input int exp_runlen, input string tag);
    int a, budget, skips;
    @(posedge clk); #1;
    setup_frame(addr, idx, r, d, p);
    enable = 1'b1; frame_start = 1'b1; a = cyc; skips = 0;
    // extra pulses on cycles a+1, a+3, a+5: always inside the frame
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      frame_start = (j % 2 == 1) && ((j + 1) / 2 <= k);
      enable = (j % 2 == 1) ? en[(j - 1) / 2] : 1'b1;
      if (frame_start && enable) skips++;
    end
    frame_start = 1'b0; enable = 1'b1;
    budget = 0;
    while (rel_cyc < 0 && budget < 1000) begin wait_neg(); budget++; end
    check({tag, "_release_seen"}, rel_cyc >= 0, 1);
    budget = 0;
    while (busy && budget < 10) begin wait_neg(); budget++; end
    exp_frames   += CW'(exp_done);
    exp_timeouts += CW'(!exp_done);
    exp_skips    += CW'(skips);
    check({tag, "_req_count"}, req_cnt, 1);
    check({tag, "_rel_count"}, rel_cnt, 1);
    check({tag, "_req_rel_overlap"}, both_cnt, 0);
    check({tag, "_valid_cycles"}, valid_cycles, r + 1);
    check({tag, "_dma_addr"}, valid_addr, addr);
    check({tag, "_dma_addr_stable"}, addr_bad, 0);
    check({tag, "_start_latency"}, hs_cyc - a, L + 2 + r);
    check({tag, "_run_length"}, rel_cyc - hs_cyc, exp_runlen + 1);
    check({tag, "_current_index"}, current_index, idx);
    check({tag, "_frame_count"}, frame_count, exp_frames);
    check({tag, "_skip_count"}, skip_count, exp_skips);
    check({tag, "_timeout_count"}, timeout_count, exp_timeouts);
    check({tag, "_idle"}, {busy, dma_valid}, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] idx;
    int            r, d, p, k;
    logic [2:0]    en;
    bit            exp_done;
    int            exp_runlen;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    int a, budget, r, d, p, k;
    logic [2:0] en;
    bit dw;

    vecs[0] = '{32'h1000_0000, 2'd0, 0, 10,   0, 0, 3'b111, 1'b1, 10};
    vecs[1] = '{32'h2000_0040, 2'd1, 5,  4,   0, 0, 3'b111, 1'b1, 4};
    vecs[2] = '{32'h3000_0080, 2'd2, 0, 20,   0, 3, 3'b111, 1'b1, 20};
    vecs[3] = '{32'h4000_00C0, 2'd3, 1,  0, 100, 0, 3'b111, 1'b0, 100};
    vecs[4] = '{32'h5000_0100, 2'd0, 0, 100, 100, 0, 3'b111, 1'b1, 100};
    vecs[5] = '{32'h6000_0140, 2'd1, 2, 101, 100, 2, 3'b010, 1'b0, 100};
    vecs[6] = '{32'h7000_0180, 2'd2, 0,  0,   1, 3, 3'b111, 1'b0, 1};
    vecs[7] = '{32'h8000_01C0, 2'd3, 3,  1,   1, 1, 3'b111, 1'b1, 1};

    reset = 1'b1; cke = 1'b1; enable = 1'b0; frame_start = 1'b0; param_timeout = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_neg();
    check("reset_busy", busy, 0);
    check("reset_pulses", {buffer_request, buffer_release, dma_valid}, 0);
    check("reset_dma_addr", dma_addr, 0);
    check("reset_index", current_index, 0);
    check("reset_counters", {frame_count, skip_count, timeout_count}, 0);

    // frame_start while disabled is ignored entirely
    @(posedge clk); #1 frame_start = 1'b1; enable = 1'b0;
    @(posedge clk); #1 frame_start = 1'b0;
    wait_neg();
    check("disabled_no_request", {buffer_request, busy}, 0);
    check("disabled_no_skip", skip_count, 0);

    // dma_done outside RUN is ignored
    extra_done = 1'b1;
    wait_neg();
    extra_done = 1'b0;
    wait_neg();
    check("stray_done_frames", frame_count, 0);
    check("stray_done_idle", busy, 0);

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].addr, vecs[i].idx, vecs[i].r, vecs[i].d, vecs[i].p, vecs[i].k,
                vecs[i].en, vecs[i].exp_done, vecs[i].exp_runlen, $sformatf("vec%0d", i));

    // cke low stalls the timeout timer, then holds the release pulse
    @(posedge clk); #1;
    setup_frame(32'h9000_0200, 2'd2, 0, 0, 10);
    enable = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    budget = 0;
    while (hs_cyc < 0 && budget < 50) begin wait_neg(); budget++; end
    check("cke_handshake_seen", hs_cyc >= 0, 1);
    repeat (2) wait_neg();
    cke = 1'b0;
    repeat (5) wait_neg();
    check("cke_stall_busy", busy, 1);
    cke = 1'b1;
    budget = 0;
    while (rel_cyc < 0 && budget < 100) begin wait_neg(); budget++; end
    check("cke_run_length", rel_cyc - hs_cyc, 16);
    cke = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_neg();
      check("cke_release_held", {buffer_release, busy}, 2'b11);
    end
    cke = 1'b1;
    wait_neg();
    check("cke_release_done", {buffer_release, busy}, 0);
    exp_timeouts += 1'b1;
    check("cke_timeout_count", timeout_count, exp_timeouts);
    check("cke_rel_count", rel_cnt, 1);

    // reset in RUN aborts without a release
    @(posedge clk); #1;
    setup_frame(32'hA000_0240, 2'd1, 0, 0, 0);
    enable = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    budget = 0;
    while (hs_cyc < 0 && budget < 50) begin wait_neg(); budget++; end
    check("rst_handshake_seen", hs_cyc >= 0, 1);
    repeat (3) wait_neg();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_neg();
    exp_q.delete();
    exp_frames = '0; exp_skips = '0; exp_timeouts = '0;
    check("rst_busy", busy, 0);
    check("rst_pulses", {buffer_request, buffer_release, dma_valid}, 0);
    check("rst_dma_addr", dma_addr, 0);
    check("rst_index", current_index, 0);
    check("rst_counters", {frame_count, skip_count, timeout_count}, 0);
    repeat (5) wait_neg();
    check("rst_no_release", rel_cnt, 0);

    // random frames against the arithmetic outcome model
    for (int i = 0; i < 20; i++) begin
      r  = $urandom_range(0, 4);
      p  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
      d  = $urandom_range(0, 35);
      if (p == 0 && d == 0) d = $urandom_range(1, 35);
      k  = $urandom_range(0, 3);
      en = 3'($urandom_range(0, 7));
      dw = (d > 0) && ((p == 0) || (d <= p));
      run_frame($urandom, 2'($urandom_range(0, 3)), r, d, p, k, en, dw, dw ? d : p,
                $sformatf("rnd%0d", i));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
